// File: rtl/ws2812_bit_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ws2812_bit_encoder                                               |
// | Purpose : 24-bit GRB pixel stream to WS2812 single-wire NRZ waveform.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module ws2812_bit_encoder #(
  parameter int T0H          = 40,
  parameter int T0L          = 85,
  parameter int T1H          = 80,
  parameter int T1L          = 45,
  parameter int RESET_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pll_locked,
  input  logic [23:0] pix_data,
  input  logic        pix_valid,
  input  logic        pix_last,
  output logic        pix_ready,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int c_max_a   = (RESET_CYCLES > T0L) ? RESET_CYCLES : T0L;
  localparam int c_max_b   = (c_max_a > T1H) ? c_max_a : T1H;
  localparam int c_max_c   = (c_max_b > T0H) ? c_max_b : T0H;
  localparam int c_cnt_max = (c_max_c > T1L) ? c_max_c : T1L;
  localparam int c_cw      = $clog2(c_cnt_max + 1);

  typedef enum logic [2:0] {
    S_LOCKWAIT = 3'd0,
    S_LATCH    = 3'd1,
    S_IDLE     = 3'd2,
    S_HIGH     = 3'd3,
    S_LOW      = 3'd4
  } state_t;

  state_t            r_state, w_state;
  logic [c_cw-1:0]   r_cnt, w_cnt;
  logic [23:0]       r_shift, w_shift;
  logic [4:0]        r_bit_idx, w_bit_idx;
  logic              r_cur_last, w_cur_last;
  logic [23:0]       r_hold_data, w_hold_data;
  logic              r_hold_last, w_hold_last;
  logic              r_hold_full, w_hold_full;
  logic              r_last_pending, w_last_pending;
  logic              r_dout, r_busy, r_frame_done, r_underrun;
  logic              w_frame_done, w_underrun;
  logic              w_ready, w_xfer;

  function automatic logic [c_cw-1:0] f_high_len(input logic b);
    return b ? c_cw'(T1H - 1) : c_cw'(T0H - 1);
  endfunction

  function automatic logic [c_cw-1:0] f_low_len(input logic b);
    return b ? c_cw'(T1L - 1) : c_cw'(T0L - 1);
  endfunction

  assign w_ready = pll_locked & ~r_hold_full & ~r_last_pending &
                   (r_state != S_LOCKWAIT) & (r_state != S_LATCH);
  assign w_xfer  = pix_valid & w_ready;

  always_comb begin
    w_state        = r_state;
    w_cnt          = r_cnt;
    w_shift        = r_shift;
    w_bit_idx      = r_bit_idx;
    w_cur_last     = r_cur_last;
    w_hold_data    = r_hold_data;
    w_hold_last    = r_hold_last;
    w_hold_full    = r_hold_full;
    w_last_pending = r_last_pending;
    w_frame_done   = 1'b0;
    w_underrun     = 1'b0;

    if (w_xfer) begin
      w_hold_data = pix_data;
      w_hold_last = pix_last;
      w_hold_full = 1'b1;
      if (pix_last) w_last_pending = 1'b1;
    end

    // A hold load never coincides with a transfer: pix_ready needs an empty hold.
    case (r_state)
      S_LOCKWAIT: begin
        if (pll_locked) begin
          w_state = S_LATCH;
          w_cnt   = c_cw'(RESET_CYCLES - 1);
        end
      end
      S_LATCH: begin
        if (r_cnt == '0) begin
          w_state        = S_IDLE;
          w_frame_done   = r_last_pending;
          w_last_pending = 1'b0;
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_IDLE: begin
        if (r_hold_full) begin
          w_state     = S_HIGH;
          w_shift     = r_hold_data;
          w_cur_last  = r_hold_last;
          w_hold_full = 1'b0;
          w_bit_idx   = 5'd23;
          w_cnt       = f_high_len(r_hold_data[23]);
        end
      end
      S_HIGH: begin
        if (r_cnt == '0) begin
          w_state = S_LOW;
          w_cnt   = f_low_len(r_shift[23]);
        end else begin
          w_cnt = r_cnt - 1'b1;
        end
      end
      S_LOW: begin
        if (r_cnt != '0) begin
          w_cnt = r_cnt - 1'b1;
        end else if (r_bit_idx != 5'd0) begin
          w_state   = S_HIGH;
          w_shift   = {r_shift[22:0], 1'b0};
          w_bit_idx = r_bit_idx - 5'd1;
          w_cnt     = f_high_len(r_shift[22]);
        end else if (r_hold_full) begin
          w_state     = S_HIGH;
          w_shift     = r_hold_data;
          w_cur_last  = r_hold_last;
          w_hold_full = 1'b0;
          w_bit_idx   = 5'd23;
          w_cnt       = f_high_len(r_hold_data[23]);
        end else if (r_cur_last) begin
          w_state = S_LATCH;
          w_cnt   = c_cw'(RESET_CYCLES - 1);
        end else begin
          w_state    = S_IDLE;
          w_underrun = 1'b1;
        end
      end
      default: begin
        w_state = S_LOCKWAIT;
        w_cnt   = '0;
      end
    endcase

    // Lock loss overrides everything and discards any pixel in flight.
    if (!pll_locked && (r_state != S_LOCKWAIT)) begin
      w_state        = S_LOCKWAIT;
      w_cnt          = '0;
      w_hold_full    = 1'b0;
      w_last_pending = 1'b0;
      w_cur_last     = 1'b0;
      w_frame_done   = 1'b0;
      w_underrun     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_LOCKWAIT;
      r_cnt          <= '0;
      r_shift        <= '0;
      r_bit_idx      <= '0;
      r_cur_last     <= 1'b0;
      r_hold_data    <= '0;
      r_hold_last    <= 1'b0;
      r_hold_full    <= 1'b0;
      r_last_pending <= 1'b0;
      r_dout         <= 1'b0;
      r_busy         <= 1'b0;
      r_frame_done   <= 1'b0;
      r_underrun     <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_cnt          <= w_cnt;
      r_shift        <= w_shift;
      r_bit_idx      <= w_bit_idx;
      r_cur_last     <= w_cur_last;
      r_hold_data    <= w_hold_data;
      r_hold_last    <= w_hold_last;
      r_hold_full    <= w_hold_full;
      r_last_pending <= w_last_pending;
      r_dout         <= (w_state == S_HIGH);
      r_busy         <= (w_state != S_IDLE) | w_hold_full;
      r_frame_done   <= w_frame_done;
      r_underrun     <= w_underrun;
    end
  end

  assign pix_ready  = w_ready;
  assign dout       = r_dout;
  assign busy       = r_busy;
  assign frame_done = r_frame_done;
  assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_ws2812_bit_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ws2812_bit_encoder                                            |
// | Purpose : Directed self-checking bench for ws2812_bit_encoder.             |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_ws2812_bit_encoder;

  localparam int c_t0h  = 40;
  localparam int c_t1h  = 80;
  localparam int c_bitp = 125;
  localparam int c_pixp = 24 * c_bitp;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pll_locked = 1'b1;
  logic [23:0] pix_data = '0;
  logic        pix_valid = 1'b0;
  logic        pix_last = 1'b0;
  logic        pix_ready, dout, busy, frame_done, underrun;

  int n_tests = 0;
  int n_fail  = 0;
  int n_fd    = 0;
  int n_ur    = 0;
  logic [23:0] px_tab [0:3];

  ws2812_bit_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_locked (pll_locked),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_last   (pix_last),
    .pix_ready  (pix_ready),
    .dout       (dout),
    .busy       (busy),
    .frame_done (frame_done),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  always begin
    @(posedge clk);
    #1;
    if (frame_done) n_fd++;
    if (underrun)   n_ur++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic exp_dout(input int t);
    int p  = t / c_pixp;
    int b  = (t / c_bitp) % 24;
    int ph = t % c_bitp;
    logic [23:0] v = px_tab[p];
    return (ph < (v[23 - b] ? c_t1h : c_t0h));
  endfunction

  task automatic wait_ready(output int n, output int hi);
    n  = 0;
    hi = 0;
    do begin
      @(negedge clk);
      n++;
      if (dout) hi++;
    end while (!pix_ready && n < 20000);
  endtask

  task automatic send(input logic [23:0] d, input logic l);
    int w = 0;
    pix_data  = d;
    pix_last  = l;
    pix_valid = 1'b1;
    while (!pix_ready && w < 20000) begin
      @(negedge clk);
      w++;
    end
    @(negedge clk);
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic feed(input int npx);
    for (int i = 0; i < npx; i++) begin
      int w = 0;
      pix_data  = px_tab[i];
      pix_last  = (i == npx - 1);
      pix_valid = 1'b1;
      while (!pix_ready && w < 20000) begin
        @(negedge clk);
        w++;
      end
      @(negedge clk);
    end
    pix_valid = 1'b0;
    pix_last  = 1'b0;
  endtask

  task automatic check_wave(input string tag, input int npx, input bit sync);
    int err = 0;
    int w   = 0;
    if (sync) begin
      while (!dout && w < 1000) begin
        @(negedge clk);
        w++;
      end
    end else begin
      @(negedge clk);
    end
    for (int t = 0; t < npx * c_pixp; t++) begin
      if (t > 0) @(negedge clk);
      if (dout !== exp_dout(t)) err++;
    end
    check(tag, err, 0);
  endtask

  task automatic check_latch(input string tag, input int fd_exp);
    int n, hi, fd0;
    fd0 = n_fd;
    wait_ready(n, hi);
    check({tag, "_len"}, n, 5001);
    check({tag, "_dout_lo"}, hi, 0);
    check({tag, "_frame_done"}, n_fd - fd0, fd_exp);
  endtask

  initial begin
    int n, hi, fd0, ur0;

    // Reset values with the clock running.
    #1;
    check("rst_dout", dout, 0);
    check("rst_ready", pix_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_fd", frame_done, 0);
    check("rst_ur", underrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n, hi);
    check("boot_latch_len", n, 5001);
    check("boot_dout_lo", hi, 0);
    check("boot_busy", busy, 0);

    // Single last pixel, one-cycle start latency, then latch and frame_done.
    px_tab[0] = 24'hA50000;
    send(24'hA50000, 1'b1);
    check("acc_ready", pix_ready, 0);
    check("acc_busy", busy, 1);
    check("acc_dout", dout, 0);
    check_wave("wave_a50000", 1, 1'b0);
    check_latch("latch_a5", 1);

    // Three back-to-back pixels with no gap.
    px_tab[0] = 24'hFFFFFF;
    px_tab[1] = 24'h000000;
    px_tab[2] = 24'h0F0F0F;
    fd0 = n_fd;
    fork
      feed(3);
      check_wave("wave_3px", 3, 1'b1);
    join
    check_latch("latch_3px", 1);
    check("fd_3px_total", n_fd - fd0, 1);

    // Starvation mid-frame.
    px_tab[0] = 24'h800000;
    ur0 = n_ur;
    send(24'h800000, 1'b0);
    check_wave("wave_800000", 1, 1'b0);
    @(negedge clk);
    check("ur_pulse", underrun, 1);
    hi = 0;
    repeat (299) begin
      @(negedge clk);
      if (dout) hi++;
    end
    check("ur_gap_lo", hi, 0);
    check("ur_gap_ready", pix_ready, 1);
    check("ur_gap_busy", busy, 0);
    px_tab[0] = 24'h00FF00;
    send(24'h00FF00, 1'b1);
    check_wave("wave_after_ur", 1, 1'b0);
    check_latch("latch_ur", 1);
    check("ur_count", n_ur - ur0, 1);

    // Loss of lock at cycle 60 of a T1H phase.
    px_tab[0] = 24'hFFFFFF;
    fd0 = n_fd;
    ur0 = n_ur;
    send(24'hFFFFFF, 1'b1);
    hi = 0;
    repeat (60) begin
      @(negedge clk);
      if (dout) hi++;
    end
    check("lol_pre_hi", hi, 60);
    pll_locked = 1'b0;
    @(negedge clk);
    check("lol_dout", dout, 0);
    check("lol_ready", pix_ready, 0);
    hi = 0;
    repeat (99) begin
      @(negedge clk);
      if (dout) hi++;
    end
    check("lol_lo", hi, 0);
    pll_locked = 1'b1;
    check_latch("relock", 0);
    check("lol_no_ur", n_ur - ur0, 0);
    check("lol_no_fd", n_fd - fd0, 0);
    px_tab[0] = 24'h0F0F0F;
    send(24'h0F0F0F, 1'b1);
    check_wave("wave_relock", 1, 1'b0);
    check_latch("latch_relock", 1);

    // Asynchronous reset mid-bit.
    send(24'hFFFFFF, 1'b0);
    repeat (10) @(negedge clk);
    check("arst_pre_dout", dout, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dout", dout, 0);
    check("arst_ready", pix_ready, 0);
    check("arst_busy", busy, 0);
    check("arst_fd", frame_done, 0);
    check("arst_ur", underrun, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n, hi);
    check("arst_latch_len", n, 5001);
    check("arst_dout_lo", hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
